// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: port identifiers and the
// request bundle carried from a requester to the BRAM.
package bram_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU  = 1'b0;
  localparam port_id_t PORT_HOST = 1'b1;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;

  // Default-width request bundle; the arbiter declares the same layout at its own widths.
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } bram_req_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port block RAM with synchronous read (read-before-write on the same edge).
// Contents are deliberately not reset.
module bram_sp #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the CPU (port 0) and
// the host loader (port 1); host_hold gives the host exclusive ownership.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_hold,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  busy
);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t     req0, req1, sel_req;
  logic     grant0, grant1, accept;
  port_id_t last_grant, rd_owner;
  logic     rd_pending;
  logic     bram_we;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  assign req0 = {p0_we, p0_addr, p0_wdata};
  assign req1 = {p1_we, p1_addr, p1_wdata};

  // Ties go to whichever port did not win the previous accepted request.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (host_hold) begin
        grant1 = p1_valid;
      end else if (p0_valid && p1_valid) begin
        if (last_grant == PORT_HOST) grant0 = 1'b1;
        else                         grant1 = 1'b1;
      end else begin
        grant0 = p0_valid;
        grant1 = p1_valid;
      end
    end
  end

  assign p0_ready = grant0;
  assign p1_ready = grant1;
  assign accept   = grant0 | grant1;
  assign busy     = accept;
  assign sel_req  = grant1 ? req1 : req0;
  assign bram_we  = accept & sel_req.we;

  bram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk  (clk),
    .we   (bram_we),
    .addr (sel_req.addr),
    .din  (sel_req.wdata),
    .dout (bram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_HOST;
      rd_pending <= 1'b0;
      rd_owner   <= PORT_CPU;
    end else begin
      rd_pending <= accept & ~sel_req.we;
      if (accept) begin
        last_grant <= grant1 ? PORT_HOST : PORT_CPU;
        rd_owner   <= grant1 ? PORT_HOST : PORT_CPU;
      end
    end
  end

  assign p0_rvalid = rd_pending & (rd_owner == PORT_CPU);
  assign p1_rvalid = rd_pending & (rd_owner == PORT_HOST);

  // Read data is shown straight from the BRAM on the rvalid cycle and held afterwards.
  assign p0_rdata = p0_rvalid ? bram_dout : rdata0_q;
  assign p1_rdata = p1_rvalid ? bram_dout : rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= p0_rdata;
      rdata1_q <= p1_rdata;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: accepted requests update a reference memory
// and queue expected read data; a negedge monitor checks grants and read returns.
module tb_bram_arbiter;

  logic       clk, rst, host_hold;
  logic       p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [9:0] p0_addr;
  logic [7:0] p0_wdata, p0_rdata;
  logic       p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [9:0] p1_addr;
  logic [7:0] p1_wdata, p1_rdata;
  logic       busy;

  bram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .host_hold(host_hold),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] ref_mem [1024];
  exp_t       q0[$], q1[$];
  int         grant_log[$];
  int         last_win = 1;
  logic [7:0] exp_rd0 = '0, exp_rd1 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: arbitration rules, memory contents and one-cycle read return.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      grant_log.delete();
      last_win = 1;
      exp_rd0  = '0;
      exp_rd1  = '0;
      check_output("rst_ready0", {31'b0, p0_ready}, 0);
      check_output("rst_ready1", {31'b0, p1_ready}, 0);
      check_output("rst_rvalid0", {31'b0, p0_rvalid}, 0);
      check_output("rst_rvalid1", {31'b0, p1_rvalid}, 0);
      check_output("rst_rdata0", {24'b0, p0_rdata}, 0);
      check_output("rst_rdata1", {24'b0, p1_rdata}, 0);
    end else begin
      logic e0, e1;
      e0 = !host_hold && p0_valid && (!p1_valid || last_win == 1);
      e1 = p1_valid && (host_hold || !p0_valid || last_win == 0);
      check_output("ready0", {31'b0, p0_ready}, {31'b0, e0});
      check_output("ready1", {31'b0, p1_ready}, {31'b0, e1});
      check_output("ready_onehot", {31'b0, p0_ready & p1_ready}, 0);
      check_output("busy", {31'b0, busy}, {31'b0, e0 | e1});

      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        check_output("rvalid0", {31'b0, p0_rvalid}, 1);
        check_output("rdata0", {24'b0, p0_rdata}, {24'b0, q0[0].data});
        exp_rd0 = q0[0].data;
        void'(q0.pop_front());
      end else begin
        check_output("rvalid0_idle", {31'b0, p0_rvalid}, 0);
        check_output("rdata0_hold", {24'b0, p0_rdata}, {24'b0, exp_rd0});
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        check_output("rvalid1", {31'b0, p1_rvalid}, 1);
        check_output("rdata1", {24'b0, p1_rdata}, {24'b0, q1[0].data});
        exp_rd1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        check_output("rvalid1_idle", {31'b0, p1_rvalid}, 0);
        check_output("rdata1_hold", {24'b0, p1_rdata}, {24'b0, exp_rd1});
      end

      if (p0_valid && p0_ready) begin
        if (p0_we) ref_mem[p0_addr] = p0_wdata;
        else       q0.push_back('{cyc + 1, ref_mem[p0_addr]});
        last_win = 0;
        grant_log.push_back(0);
      end else if (p1_valid && p1_ready) begin
        if (p1_we) ref_mem[p1_addr] = p1_wdata;
        else       q1.push_back('{cyc + 1, ref_mem[p1_addr]});
        last_win = 1;
        grant_log.push_back(1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Presents one request and holds it until accepted; called and returns at posedge+1.
  task automatic apply_stimulus(input int port, input logic we, input logic [9:0] addr,
                                input logic [7:0] data, input int budget, output int waited);
    logic rdy;
    if (port == 0) begin p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data; end
    else           begin p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data; end
    waited = 0;
    forever begin
      @(negedge clk);
      rdy = (port == 0) ? p0_ready : p1_ready;
      if (rdy) break;
      waited++;
      if (waited >= budget) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL accept_timeout: port %0d addr 0x%0h not accepted after %0d cycles", port, addr, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port == 0) p0_valid = 1'b0;
    else           p1_valid = 1'b0;
  endtask

  task automatic rand_traffic(input int port, input int n);
    int         w;
    logic       we;
    logic [9:0] a;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      we = ($urandom_range(0, 2) == 0);
      a  = 10'($urandom_range(0, 31));
      d  = 8'($urandom);
      apply_stimulus(port, we, a, d, 64, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic rand_hold(input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(10, 20));
      host_hold = 1'b1;
      idle($urandom_range(1, 4));
      host_hold = 1'b0;
    end
  endtask

  initial begin
    int w, w0, w1, drop_cyc, acc_cyc;
    rst = 1'b1; host_hold = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 32; i++) apply_stimulus(i % 2, 1'b1, 10'(i), 8'(i) ^ 8'h3C, 8, w);
    apply_stimulus(1, 1'b1, 10'h020, 8'h77, 8, w);

    // Port 0 alone: write then read back.
    apply_stimulus(0, 1'b1, 10'h010, 8'h5A, 8, w);
    check_output("p0_write_wait", w, 0);
    apply_stimulus(0, 1'b0, 10'h010, 8'h00, 8, w);
    check_output("p0_read_wait", w, 0);
    idle(2);

    // Continuous contention right after reset alternates grants starting at port 0.
    do_reset();
    fork
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, 10'h001, 8'h00, 8, w0);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 1'b0, 10'h002, 8'h00, 8, w1);
    join
    check_output("rr_log_size", (grant_log.size() >= 4) ? 1 : 0, 1);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) check_output("rr_order", grant_log[i], i % 2);
    idle(2);

    // Host hold: CPU request waits, host loads, CPU goes through once hold drops.
    host_hold = 1'b1;
    drop_cyc  = 0;
    acc_cyc   = 0;
    fork
      begin
        apply_stimulus(0, 1'b0, 10'h100, 8'h00, 100, w0);
        acc_cyc = cyc - 1;
      end
      begin
        for (int i = 0; i < 16; i++) apply_stimulus(1, 1'b1, 10'h100 + 10'(i), 8'(i), 8, w1);
        idle(6);
        host_hold = 1'b0;
        drop_cyc  = cyc;
      end
    join
    check_output("hold_release_latency", (acc_cyc - drop_cyc <= 2) ? 1 : 0, 1);
    for (int i = 0; i < 16; i++) apply_stimulus(i % 2, 1'b0, 10'h100 + 10'(i), 8'h00, 8, w);

    // Top address write followed immediately by a read of the same location.
    apply_stimulus(0, 1'b1, 10'h3FF, 8'hA5, 8, w);
    apply_stimulus(0, 1'b0, 10'h3FF, 8'h00, 8, w);
    idle(2);

    // Reset lands while a port 1 read is in flight.
    apply_stimulus(1, 1'b0, 10'h020, 8'h00, 8, w);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    fork
      apply_stimulus(0, 1'b0, 10'h020, 8'h00, 8, w0);
      apply_stimulus(1, 1'b0, 10'h010, 8'h00, 8, w1);
    join
    check_output("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    idle(2);

    fork
      rand_traffic(0, 150);
      rand_traffic(1, 150);
      rand_hold(6);
    join
    idle(4);
    check_output("lost_reads_p0", q0.size(), 0);
    check_output("lost_reads_p1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
